// File: rtl/conv_accumulator_if.sv
// conv_accumulator_if
//   Handshake bundle for the accumulator: one tap-rate input stream and one
//   pixel-rate output stream, both valid/ready.
//   Ports (signals):
//     in_valid, in_data[DATA_WIDTH], in_ready   - tap product stream
//     out_valid, out_data[DATA_WIDTH], out_ready - completed pixel stream
//   Modports:
//     slave  - the accumulator side (consumes taps, produces pixels)
//     master - the environment side (produces taps, consumes pixels)
interface conv_accumulator_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_accumulator.sv
// conv_accumulator
//   Sums TAPS signed tap products per convolution window into an ACC_WIDTH
//   accumulator, optionally rectifies, saturates to DATA_WIDTH and presents
//   one pixel per window on a valid/ready output.
//   Ports:
//     clk      - rising-edge clock
//     rst      - synchronous active-high reset
//     bus      - conv_accumulator_if.slave (tap input / pixel output streams)
//     tap_cnt  - taps accepted so far in the current window
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   S_IDLE  | tap_cnt == 0, next accepted tap starts a new window
//   S_ACCUM | 0 < tap_cnt < TAPS, window partially summed
module conv_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 9,
  parameter int ACC_WIDTH  = 32,
  parameter int RELU_EN    = 1,
  localparam int CNT_W     = $clog2(TAPS) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_accumulator_if.slave    bus,
  output logic [CNT_W-1:0]     tap_cnt
);

  typedef enum logic {S_IDLE, S_ACCUM} state_e;

  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_WIDTH-1:0] PIX_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] PIX_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]             tap_cnt_q, tap_cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;

  state_e                       state;
  logic                         last_tap;
  logic                         in_fire;
  logic signed [ACC_WIDTH-1:0]  in_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  rect;
  logic [DATA_WIDTH-1:0]        sat;

  assign state    = (tap_cnt_q == '0) ? S_IDLE : S_ACCUM;
  assign last_tap = (tap_cnt_q == LAST_TAP);

  // Only the window-closing tap needs the output register free; it may
  // also complete in the same cycle the old pixel is taken.
  assign bus.in_ready = !rst && !(last_tap && out_valid_q && !bus.out_ready);
  assign in_fire      = bus.in_valid && bus.in_ready;

  always_comb begin
    in_ext = ACC_WIDTH'($signed(bus.in_data));
    sum    = ((state == S_IDLE) ? '0 : acc_q) + in_ext;
    rect   = ((RELU_EN != 0) && sum[ACC_WIDTH-1]) ? '0 : sum;
    if (rect > PIX_MAX)      sat = PIX_MAX[DATA_WIDTH-1:0];
    else if (rect < PIX_MIN) sat = PIX_MIN[DATA_WIDTH-1:0];
    else                     sat = rect[DATA_WIDTH-1:0];
  end

  always_comb begin
    acc_d       = acc_q;
    tap_cnt_d   = tap_cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    if (in_fire) begin
      acc_d = sum;
      if (last_tap) begin
        tap_cnt_d   = '0;
        out_valid_d = 1'b1;
        out_data_d  = sat;
      end else begin
        tap_cnt_d = tap_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      tap_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      acc_q       <= acc_d;
      tap_cnt_q   <= tap_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign tap_cnt       = tap_cnt_q;

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Downstream stage of the per-tap multiply-add unit: collects the stream of signed per-tap products for one convolution window, sums exactly TAPS of them into a wide accumulator, then applies optional ReLU and saturation and presents one DATA_WIDTH output pixel over a valid/ready handshake. It converts a tap-rate stream into a pixel-rate stream and absorbs output backpressure without losing taps.

## Interface

- DATA_WIDTH, 16: width of the input product and the output pixel; two's complement.
- TAPS, 9: products summed per output pixel; legal values are 1 to 1024.
- ACC_WIDTH, 32: accumulator width; must be >= DATA_WIDTH + clog2(TAPS).
- RELU_EN, 1: when 1, negative sums are clamped to 0 before saturation.

- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data holds a valid tap product.
- in_data  input  DATA_WIDTH  signed tap product (weight*data+bias from the multiply-add stage).
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  out_data holds a completed pixel.
- out_data  output  DATA_WIDTH  signed, saturated (and optionally rectified) window sum.
- out_ready  input  1  consumer takes out_data this cycle.
- tap_cnt  output  clog2(TAPS)+1  taps accepted so far in the current window (debug/verification).

## Operation

- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- Two states, encoded by tap_cnt:
  - IDLE (tap_cnt == 0): the first accepted tap loads acc = sign-extend(in_data), tap_cnt becomes 1.
  - ACCUM (0 < tap_cnt < TAPS): each accepted tap sets acc = acc + sign-extend(in_data) and increments tap_cnt.
  - Accepting the tap that makes the count reach TAPS ends the window:
    - final sum = acc + sign-extend(in_data), or sign-extend(in_data) alone when TAPS == 1;
    - final sum is written to the output register, out_valid is set, tap_cnt returns to 0.
- Output conversion of the final sum s (ACC_WIDTH, signed):
  - if RELU_EN and s < 0, s = 0;
  - then clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- in_ready = !rst && !(tap_cnt == TAPS-1 && out_valid && !out_ready).
  - Non-final taps are always accepted, even while an undrained pixel waits.
  - Only the final tap of a window stalls on a full, undrained output register.
- The final tap is accepted in the same cycle an output transfer occurs. The old pixel leaves, the new one loads, and out_valid stays 1.
- An output transfer with no new pixel completing clears out_valid.
- out_data and out_valid hold stable while out_valid && !out_ready.
- in_valid low: no state change except output draining. in_data is ignored when not transferred.
- The accumulator never wraps, given the ACC_WIDTH constraint.

## Timing

- Reset (rst high at a rising edge) gives:
  - out_valid = 0, out_data = 0, tap_cnt = 0, acc = 0;
  - in_ready = 0 while rst is high, and 1 in the first cycle after rst is released.
- Reset mid-window discards the partial sum and any pending pixel. The next accepted tap starts a new window.
- Latency: out_valid rises on the edge that accepts the final tap, so out_data is visible in the following cycle (1 cycle).
- Throughput: one tap per cycle sustained. With out_ready held high, back-to-back windows produce one pixel every TAPS cycles with no bubbles.
- No combinational path from in_valid or in_data to any output. out_ready reaches in_ready combinationally only.

## Test plan

- Ones: TAPS=9, RELU_EN=1, 9 taps of 1 back to back, out_ready=1 -> out_valid for one cycle, out_data=9, tap_cnt returns to 0.
- ReLU and sign: taps {3,-4,-4,0,0,0,0,0,0} -> out_data=0. Same taps with RELU_EN=0 -> out_data=-5 (0xFFFB).
- Saturation:
  - 9 taps of 32767 -> 32767 (0x7FFF);
  - RELU_EN=0, 9 taps of -32768 -> -32768 (0x8000);
  - the accumulator holds the true sums 294903 and -294912 internally.
- Backpressure:
  - complete window A (sum 9) with out_ready=0, then stream window B (taps of 2);
  - taps 1-8 of B are accepted, in_ready drops at B's 9th tap, and out_data stays 9;
  - raise out_ready for one cycle -> A transfers and B's final tap is accepted the same cycle, then out_data=18.
- Reset mid-window: accept 5 taps of 7, pulse rst for one cycle, then 9 taps of 1 -> out_data=9 (not 44); in_ready=0 during rst.
- Gapped input: 9 taps of 1 with in_valid toggling every other cycle and random out_ready -> out_data=9 and no tap lost or duplicated. Compare against a reference-model sum over 1000 random windows.
